// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: round-robin arbiter for one shared single-ported datapath.
// The grant is held until the owner ends its transaction, withdraws its
// request, or uses up its hold budget. There is always at least one no-grant
// cycle between two owners, so the downstream enables never overlap.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no grant; arbitrate among pending requests
// S_GRANT | one requester owns the resource (gnt_o one-hot)
// S_GAP   | mandatory dead cycle after a release, no grant
module rr_grant_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int MAX_HOLD = 8,
   parameter int IDW      = $clog2(NUM_REQ)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               last_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDW-1:0]     gnt_id_o,
   output logic               busy_o,
   output logic               preempt_o
);

   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0]      L_MAX_HOLD = HW'(MAX_HOLD);
   localparam logic [IDW-1:0]     L_PTR_RST  = IDW'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] L_ONE      = NUM_REQ'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t             r_state;
   logic [NUM_REQ-1:0] r_gnt;
   logic [IDW-1:0]     r_gnt_id;
   logic               r_busy;
   logic               r_preempt;
   logic [IDW-1:0]     r_ptr;
   logic [HW-1:0]      r_hold_cnt;

   state_t             w_nxt_state;
   logic [NUM_REQ-1:0] w_nxt_gnt;
   logic [IDW-1:0]     w_nxt_gnt_id;
   logic               w_nxt_busy;
   logic               w_nxt_preempt;
   logic [IDW-1:0]     w_nxt_ptr;
   logic [HW-1:0]      w_nxt_hold;

   logic               w_hi_found;
   logic [IDW-1:0]     w_hi_idx;
   logic [IDW-1:0]     w_lo_idx;
   logic [IDW-1:0]     w_win;
   logic               w_owner_req;
   logic               w_expired;

   // Round-robin pick: lowest requester above ptr, else lowest overall (wrap).
   always_comb begin
      w_hi_found = 1'b0;
      w_hi_idx   = '0;
      w_lo_idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_i[k]) begin
            w_lo_idx = IDW'(k);
            if (k > int'(r_ptr)) begin
               w_hi_found = 1'b1;
               w_hi_idx   = IDW'(k);
            end
         end
      end
      w_win = w_hi_found ? w_hi_idx : w_lo_idx;
   end

   assign w_owner_req = req_i[r_gnt_id];
   assign w_expired   = (r_hold_cnt == L_MAX_HOLD);

   // Next-state and next-output logic; registered outputs hold by default.
   always_comb begin
      w_nxt_state   = r_state;
      w_nxt_gnt     = r_gnt;
      w_nxt_gnt_id  = r_gnt_id;
      w_nxt_busy    = r_busy;
      w_nxt_preempt = 1'b0;
      w_nxt_ptr     = r_ptr;
      w_nxt_hold    = r_hold_cnt;
      case (r_state)
         S_IDLE: begin
            if (|req_i) begin
               w_nxt_state  = S_GRANT;
               w_nxt_gnt    = L_ONE << w_win;
               w_nxt_gnt_id = w_win;
               w_nxt_ptr    = w_win;
               w_nxt_busy   = 1'b1;
               w_nxt_hold   = HW'(1);
            end
         end
         S_GRANT: begin
            if (last_i || !w_owner_req || w_expired) begin
               // last_i wins over expiry, so a coincident end is not a preempt
               w_nxt_state   = S_GAP;
               w_nxt_gnt     = '0;
               w_nxt_busy    = 1'b0;
               w_nxt_preempt = !last_i && w_owner_req && w_expired;
            end else begin
               w_nxt_hold = r_hold_cnt + 1'b1;
            end
         end
         S_GAP: begin
            w_nxt_state = S_IDLE;
            w_nxt_gnt   = '0;
            w_nxt_busy  = 1'b0;
         end
         default: begin
            w_nxt_state = S_IDLE;
            w_nxt_gnt   = '0;
            w_nxt_busy  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset clears outputs without a clock edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_gnt      <= '0;
         r_gnt_id   <= '0;
         r_busy     <= 1'b0;
         r_preempt  <= 1'b0;
         r_ptr      <= L_PTR_RST;
         r_hold_cnt <= '0;
      end else begin
         r_state    <= w_nxt_state;
         r_gnt      <= w_nxt_gnt;
         r_gnt_id   <= w_nxt_gnt_id;
         r_busy     <= w_nxt_busy;
         r_preempt  <= w_nxt_preempt;
         r_ptr      <= w_nxt_ptr;
         r_hold_cnt <= w_nxt_hold;
      end
   end

   assign gnt_o     = r_gnt;
   assign gnt_id_o  = r_gnt_id;
   assign busy_o    = r_busy;
   assign preempt_o = r_preempt;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter (NUM_REQ=4, MAX_HOLD=8).
module tb_rr_grant_arbiter;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic [3:0] req_i = '0;
   logic       last_i = 1'b0;
   logic [3:0] gnt_o;
   logic [1:0] gnt_id_o;
   logic       busy_o;
   logic       preempt_o;

   int checks = 0;
   int errors = 0;

   rr_grant_arbiter #(.NUM_REQ(4), .MAX_HOLD(8)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (req_i),
      .last_i    (last_i),
      .gnt_o     (gnt_o),
      .gnt_id_o  (gnt_id_o),
      .busy_o    (busy_o),
      .preempt_o (preempt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                          input logic b, input logic p);
      chk({tag, ".gnt"}, 32'(gnt_o), 32'(g));
      chk({tag, ".id"}, 32'(gnt_id_o), 32'(id));
      chk({tag, ".busy"}, 32'(busy_o), 32'(b));
      chk({tag, ".preempt"}, 32'(preempt_o), 32'(p));
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset(input string tag);
      req_i  = '0;
      last_i = 1'b0;
      rst_i  = 1'b1;
      #2;
      chk_out(tag, 4'b0000, 2'd0, 1'b0, 1'b0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
   endtask

   initial begin
      // reset and single requester
      do_reset("rst0");
      req_i = 4'b0100;
      step();
      chk_out("single.g1", 4'b0100, 2'd2, 1'b1, 1'b0);
      step();
      chk_out("single.g2", 4'b0100, 2'd2, 1'b1, 1'b0);
      step();
      chk_out("single.g3", 4'b0100, 2'd2, 1'b1, 1'b0);
      last_i = 1'b1;
      step();
      last_i = 1'b0;
      req_i  = 4'b0000;
      chk_out("single.rel", 4'b0000, 2'd2, 1'b0, 1'b0);
      step();
      chk_out("single.idle", 4'b0000, 2'd2, 1'b0, 1'b0);

      // round-robin fairness: order 0,1,2,3,0, 2-cycle grants, 2-cycle gaps
      do_reset("rst1");
      req_i = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         logic [1:0] id;
         id = 2'(n % 4);
         step();
         chk_out($sformatf("rr%0d.g1", n), 4'b0001 << id, id, 1'b1, 1'b0);
         step();
         chk_out($sformatf("rr%0d.g2", n), 4'b0001 << id, id, 1'b1, 1'b0);
         last_i = 1'b1;
         step();
         last_i = 1'b0;
         chk_out($sformatf("rr%0d.gap", n), 4'b0000, id, 1'b0, 1'b0);
         step();
         chk_out($sformatf("rr%0d.idle", n), 4'b0000, id, 1'b0, 1'b0);
      end

      // hold-budget preemption, then withdrawal
      do_reset("rst2");
      req_i = 4'b0011;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk_out($sformatf("hold.g%0d", k), 4'b0001, 2'd0, 1'b1, 1'b0);
      end
      step();
      chk_out("hold.preempt", 4'b0000, 2'd0, 1'b0, 1'b1);
      step();
      chk_out("hold.idle", 4'b0000, 2'd0, 1'b0, 1'b0);
      step();
      chk_out("hold.next", 4'b0010, 2'd1, 1'b1, 1'b0);
      step();
      chk_out("wd.g2", 4'b0010, 2'd1, 1'b1, 1'b0);
      req_i = 4'b0001;
      step();
      chk_out("wd.rel", 4'b0000, 2'd1, 1'b0, 1'b0);
      step();
      chk_out("wd.idle", 4'b0000, 2'd1, 1'b0, 1'b0);

      // last_i on the 8th grant cycle: normal release, no preempt
      for (int k = 1; k <= 8; k++) begin
         step();
         chk_out($sformatf("sim.g%0d", k), 4'b0001, 2'd0, 1'b1, 1'b0);
      end
      last_i = 1'b1;
      step();
      last_i = 1'b0;
      req_i  = 4'b0000;
      chk_out("sim.rel", 4'b0000, 2'd0, 1'b0, 1'b0);

      // asynchronous reset during a grant to requester 3
      step();
      req_i = 4'b1000;
      step();
      step();
      chk_out("mid.g1", 4'b1000, 2'd3, 1'b1, 1'b0);
      step();
      chk_out("mid.g2", 4'b1000, 2'd3, 1'b1, 1'b0);
      #2;
      rst_i = 1'b1;
      #1;
      chk_out("mid.rst", 4'b0000, 2'd0, 1'b0, 1'b0);
      req_i = 4'b1001;
      #1;
      rst_i = 1'b0;
      #1;
      chk_out("mid.post", 4'b0000, 2'd0, 1'b0, 1'b0);
      step();
      chk_out("mid.first", 4'b0001, 2'd0, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_grant_arbiter.md
# rr_grant_arbiter

Round-robin arbiter that shares one downstream resource among `NUM_REQ` requesters. The resource is a single-ported datapath driven by per-requester input enables. It grants one requester at a time and holds the grant until the owner signals end of transaction, withdraws its request, or exceeds a hold budget. It sits in front of the shared block and drives its select/enable lines.

## Interface
- `NUM_REQ`, 4, number of requesters (2..16).
- `MAX_HOLD`, 8, maximum consecutive cycles one grant may be held (1..255).
- `IDW`, $clog2(NUM_REQ), width of the grant index (derived; do not override).

Ports:
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  reset; asynchronous and active-high.
- `req_i`  in  NUM_REQ  request vector; bit k high = requester k wants the resource.
- `last_i`  in  1  end of transaction from the current owner; ignored when no grant is active.
- `gnt_o`  out  NUM_REQ  one-hot grant vector, registered.
- `gnt_id_o`  out  IDW  binary index of the current or most recent owner, registered.
- `busy_o`  out  1  high while any grant is active.
- `preempt_o`  out  1  one-cycle pulse when a grant is revoked by hold-budget expiry.

## Operation
- **FSM states:**
  - IDLE: no grant.
  - GRANT: `gnt_o` one-hot.
  - GAP: one mandatory dead cycle with no grant.
- **IDLE:**
  - If `req_i` is nonzero, pick the first set bit searching upward, with wrap, from `ptr+1`.
  - Load `gnt_o`/`gnt_id_o`, set `ptr` to the winner, set `hold_cnt`=1, go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT:** release the grant when any of these holds (priority top-down):
  1. `last_i`=1: normal release.
  2. `req_i[gnt_id_o]`=0: requester withdrew.
  3. `hold_cnt`==MAX_HOLD: forced release; assert `preempt_o` for the following cycle.
  - On release: `gnt_o`←0, go to GAP.
  - If no release condition holds, `hold_cnt`++ and stay in GRANT.
- **GAP:** unconditional transition to IDLE. The grant is never changed without an intervening no-grant cycle.
- **Pointer rule:** `ptr` updates only on a new grant. The releasing requester has lowest priority in the next arbitration.
- **Counter:**
  - `hold_cnt` is $clog2(MAX_HOLD+1) bits wide and saturates.
  - It never exceeds MAX_HOLD.
- **Derived outputs:**
  - `busy_o` = (state==GRANT), registered alongside `gnt_o`.
  - `gnt_id_o` retains its last value in IDLE/GAP.
- **Simultaneous events:**
  - `last_i` together with budget expiry counts as a normal release; `preempt_o` stays low.
  - A new request arriving in the same cycle as a release is not considered until IDLE.
- **Reset values** (any time, including mid-grant):
  - `gnt_o`=0, `gnt_id_o`=0, `busy_o`=0, `preempt_o`=0.
  - `ptr`=NUM_REQ-1, so requester 0 wins the first contention.
  - `hold_cnt`=0, state=IDLE.
  - The first grant after reset deassertion is issued no earlier than one clock edge after reset deasserts.

## Timing
- **Request-to-grant latency:** a request sampled at edge N in IDLE gives `gnt_o` valid after edge N (1 cycle).
- **Grant duration:**
  - Owner sees grant for cycles 1..MAX_HOLD.
  - `last_i` sampled at edge M clears `gnt_o` after edge M.
- **Turnaround:**
  - Release at edge M, GAP after M, IDLE after M+1, next grant visible after M+2.
  - Minimum 2 no-grant cycles between owners; 1 from GAP, 1 from IDLE arbitration.
- **`preempt_o` pulse:** high for exactly the single cycle following the expiry edge, i.e. the GAP cycle.
- **Combinational paths:** no path from any input to any output; all outputs are flops.

## Test plan
- **Reset / single requester:**
  - Reset, then `req_i`=4'b0100 held, `last_i` pulsed on the 3rd grant cycle.
  - Expect `gnt_o`=4'b0100 and `gnt_id_o`=2 one cycle after the request.
  - Expect the grant for 3 cycles, then 0, `busy_o` following `gnt_o`, `preempt_o`=0.
- **Round-robin fairness:**
  - `req_i`=4'b1111 held, `last_i` pulsed every 2nd grant cycle.
  - Grant order: 0,1,2,3,0.
  - Each grant is 2 cycles with 2 no-grant cycles between grants.
- **Hold-budget preemption:**
  - MAX_HOLD=8, `req_i`=4'b0011 held, `last_i`=0.
  - Requester 0 granted for exactly 8 cycles, then `preempt_o`=1 for 1 cycle.
  - Requester 1 granted 2 cycles after release.
- **Withdrawal and simultaneous release:**
  - Owner 1 drops `req_i[1]` mid-grant: grant drops next edge, no preempt.
  - Separately, `last_i`=1 on the 8th cycle: release with `preempt_o`=0.
- **Reset mid-operation:**
  - Assert `rst_i` asynchronously during a grant to requester 3.
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After deassertion with `req_i`=4'b1001, requester 0 wins first.
